// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : PC and {Z,V,N} flag owner for the 16-bit single-issue core.
//               Each cycle it selects the next fetch address (PC+2, B/BR
//               target, stall hold, or halt) and drives the IF/ID squash
//               pulse after a taken branch.
//               Optional build macro FLAG_BYPASS_EN: branch conditions see
//               same-cycle flag writes.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [3:0]  br_opcode,
    input  logic [2:0]  br_cond,
    input  logic [8:0]  br_imm,
    input  logic [15:0] br_pc,
    input  logic [15:0] br_rs,
    input  logic [2:0]  flag_we,
    input  logic [2:0]  flag_in,
    input  logic        halt,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        taken,
    output logic        flush,
    output logic        halted,
    output logic [2:0]  flags
);

    localparam logic [3:0] OP_B  = 4'b1100;
    localparam logic [3:0] OP_BR = 4'b1101;
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  flush_cnt;
    logic [1:0]  next_flush_cnt;
    logic [15:0] next_pc;
    logic        next_flush;

    logic [2:0]  cond_flags;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        cond_true;
    logic        opcode_ok;
    logic [15:0] b_target;
    logic [15:0] br_target;
    logic [15:0] target;

    assign pc_plus2 = pc + 16'd2;

`ifdef FLAG_BYPASS_EN
    // Per-bit forwarding of a flag write happening in this same cycle.
    assign cond_flags = (flag_we & flag_in) | (~flag_we & flags);
`else
    assign cond_flags = flags;
`endif

    assign flag_z = cond_flags[2];
    assign flag_v = cond_flags[1];
    assign flag_n = cond_flags[0];

    // Condition code decode against the selected flag view.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = !flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = !flag_z && !flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z || !flag_n;
            3'b101:  cond_true = flag_z || flag_n;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // Branch target: B is PC-relative word offset, BR forces an even address.
    assign b_target  = br_pc + 16'd2 + {{6{br_imm[8]}}, br_imm, 1'b0};
    assign br_target = {br_rs[15:1], 1'b0};
    assign opcode_ok = (br_opcode == OP_B) || (br_opcode == OP_BR);
    assign target    = (br_opcode == OP_BR) ? br_target : b_target;

    // Branch acceptance only in RUN and only when not stalled.
    assign taken = (state == ST_RUN) && !stall && br_valid && opcode_ok && cond_true;

    // Next-state, next-PC and flush-counter selection.
    always_comb begin
        next_state     = state;
        next_pc        = pc;
        next_flush_cnt = flush_cnt;
        next_flush     = flush;
        case (state)
            ST_RUN: begin
                if (stall) begin
                    next_pc = pc;
                end else if (taken) begin
                    next_pc        = target;
                    next_state     = ST_FLUSH;
                    next_flush_cnt = FLUSH_LOAD;
                    next_flush     = 1'b1;
                end else if (halt) begin
                    next_state = ST_HALT;
                end else begin
                    next_pc = pc_plus2;
                end
            end
            ST_FLUSH: begin
                // Wrong-path branches and halts are ignored while squashing.
                if (!stall) begin
                    next_pc = pc_plus2;
                end
                next_flush_cnt = flush_cnt - 2'd1;
                if (flush_cnt <= 2'd1) begin
                    next_state     = ST_RUN;
                    next_flush     = 1'b0;
                    next_flush_cnt = 2'd0;
                end else begin
                    next_flush = 1'b1;
                end
            end
            ST_HALT: begin
                next_pc = pc;
            end
            default: begin
                next_state     = ST_RUN;
                next_flush     = 1'b0;
                next_flush_cnt = 2'd0;
            end
        endcase
    end

    // State, PC, flush pulse and halted indicator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            pc        <= RESET_PC;
            flush_cnt <= 2'd0;
            flush     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= next_state;
            pc        <= next_pc;
            flush_cnt <= next_flush_cnt;
            flush     <= next_flush;
            halted    <= (next_state == ST_HALT);
        end
    end

    // Flag register: per-bit write enables, frozen once halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 3'b000;
        end else if (state != ST_HALT) begin
            flags <= (flags & ~flag_we) | (flag_in & flag_we);
        end
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register and the {Z,V,N} flag register of the 16-bit single-issue core. Each cycle it picks the next fetch address: sequential PC+2, a B/BR branch target, a hold for a stall, or a halt.
- It also generates the flush pulse that squashes the wrong-path instruction in IF/ID.
- It sits between fetch and decode. Decode supplies the branch request; the ALU supplies flag writes.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- FLUSH_CYCLES, 1, number of cycles flush stays high after a taken branch (legal 1..3).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard stall; holds the PC and blocks branch/halt acceptance
- br_valid  in  1  decode holds a resolved branch this cycle
- br_opcode  in  4  4'b1100 = B (PC-relative), 4'b1101 = BR (register); any other value with br_valid is ignored
- br_cond  in  3  condition code C
- br_imm  in  9  signed word offset I
- br_pc  in  16  address of the branch instruction
- br_rs  in  16  register target for BR
- flag_we  in  3  per-flag write enable {Z,V,N}
- flag_in  in  3  new flag values {Z,V,N}
- halt  in  1  HLT decoded
- pc  out  16  current fetch address
- pc_plus2  out  16  pc+2, combinational
- taken  out  1  combinational; branch accepted and condition true this cycle
- flush  out  1  registered squash pulse
- halted  out  1  high in HALT state
- flags  out  3  registered {Z,V,N}

Behaviour:
- Reset (rst high at an edge, from any state, including mid-flush or HALT):
  - pc=RESET_PC, flags=3'b000, flush=0, halted=0.
  - Flush counter cleared; state goes to RUN.
- States:
  - RUN: normal operation.
  - FLUSH: counter loaded with FLUSH_CYCLES and decremented every cycle, regardless of stall; returns to RUN when the counter reaches 0.
  - HALT: absorbing; only rst exits it.
- Flag register: each bit with its flag_we bit set loads the matching flag_in bit at the edge. The flag register updates in every state except HALT.
- Condition evaluation uses flags f:
  - 000: Z==0
  - 001: Z==1
  - 010: Z==0 and N==0
  - 011: N==1
  - 100: Z==1 or N==0
  - 101: Z==1 or N==1
  - 110: V==1
  - 111: always true
- Branch targets:
  - B target = br_pc + 2 + (sign_extend(br_imm) << 1), computed mod 2^16.
  - BR target = {br_rs[15:1],1'b0}; an odd register value is forced to even.
- Next-PC priority, highest first:
  1. HALT state: pc held.
  2. stall: pc held, taken=0, halt not accepted. Decode holds its request.
  3. Branch accepted (state RUN, br_valid, legal opcode, condition true): taken=1. At the edge: pc<=target, state<=FLUSH, flush<=1 for exactly FLUSH_CYCLES cycles starting the next cycle.
  4. halt in RUN: pc held, state<=HALT, halted<=1 from the next cycle. A taken branch in the same cycle wins over halt.
  5. Otherwise: pc<=pc+2. 16'hFFFE wraps to 16'h0000.
- In FLUSH state:
  - br_valid and halt are ignored (wrong-path).
  - pc advances by +2 unless stall.
- Not-taken branch: pc<=pc+2; no flush; taken=0.
- Latency: redirect visible on pc one cycle after taken.

Optional Feature:
- FLAG_BYPASS_EN defined: condition evaluation uses, per bit, flag_in where flag_we is set in the same cycle, else the registered flag. A flag-setting ALU op and a dependent branch may therefore resolve in the same cycle.
- FLAG_BYPASS_EN undefined: conditions use registered flags only. Same-cycle writes affect branches from the next cycle.

Test Plan:
- Reset:
  - RESET_PC=16'h0000; hold rst 2 cycles → pc=0000, flags=000, flush=0, halted=0.
  - Release; 3 idle cycles → pc 0002, 0004, 0006.
- B taken, FLUSH_CYCLES=1:
  - flags Z=1; br_pc=0010, br_cond=001, br_imm=9'h1FE (−2); br_valid with B opcode.
  - → taken=1; next pc=000E; flush=1 for exactly one cycle; the following cycle pc=0010.
- BR odd target + not-taken:
  - BR, cond=111, br_rs=0x1235 → pc=0x1234.
  - Then Z=0, cond=001 → taken=0, pc+2, no flush.
- Stall precedence:
  - stall=1 with a taken branch for 2 cycles → pc unchanged, taken=0.
  - Drop stall → branch taken the next cycle.
- Halt and wrap:
  - pc=FFFE advancing → 0000.
  - halt=1 → halted=1 next cycle; pc frozen for 5 cycles despite br_valid.
  - rst → pc=RESET_PC, halted=0.
- Bypass, with FLAG_BYPASS_EN:
  - flags Z=0; same cycle flag_we=100, flag_in=100, BEQ → taken=1.
  - Without FLAG_BYPASS_EN → taken=0.
